// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, arbiter state encoding and request payload.
package wb_pkg;

    localparam int unsigned WB_DW = 16;
    localparam int unsigned WB_AW = 16;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    // Master-to-slave request payload as seen on one bus
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus; dat_o flows master->slave, dat_i flows slave->master.
interface if_wb;
    import wb_pkg::*;

    logic             clk;
    logic             rst;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_o;
    logic [WB_DW-1:0] dat_i;
    logic             ack;
    logic             stall;

    modport master (
        input  clk, rst,
        output cyc, stb, we, adr, dat_o,
        input  dat_i, ack, stall
    );

    modport slave (
        input  clk, rst,
        input  cyc, stb, we, adr, dat_o,
        output dat_i, ack, stall
    );

endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with bus lock for the whole cycle and
// an outstanding-transfer limit on the shared slave bus.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4
) (
    input logic  clk,
    input logic  rst_n,
    if_wb.slave  m0,
    if_wb.slave  m1,
    if_wb.master s
);

    localparam int unsigned   CW        = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last;
    logic          last_nxt;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_nxt;

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t sel;
    logic    gnt0;
    logic    gnt1;
    logic    full;
    logic    busy;
    logic    stb_fwd;
    logic    issue;

    assign req0 = '{cyc: m0.cyc, stb: m0.stb, we: m0.we, adr: m0.adr, dat: m0.dat_o};
    assign req1 = '{cyc: m1.cyc, stb: m1.stb, we: m1.we, adr: m1.adr, dat: m1.dat_o};

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);
    assign full = (outst == OUTST_MAX);
    assign busy = (outst != '0);

    // Request mux: all-zero while idle
    always_comb begin
        sel = '0;
        if (gnt0) begin
            sel = req0;
        end else if (gnt1) begin
            sel = req1;
        end
    end

    // Slave side: cyc stays up after the owner lets go until every issued transfer is acked
    assign stb_fwd = sel.cyc & sel.stb & ~full;
    assign s.cyc   = sel.cyc | ((gnt0 | gnt1) & busy);
    assign s.stb   = stb_fwd;
    assign s.we    = sel.we;
    assign s.adr   = sel.adr;
    assign s.dat_o = sel.dat;

    assign issue = stb_fwd & ~s.stall;

    // Master side: the loser only ever sees stall
    assign m0.stall = gnt0 ? (s.stall | full) : 1'b1;
    assign m0.ack   = gnt0 & s.ack;
    assign m0.dat_i = gnt0 ? s.dat_i : '0;
    assign m1.stall = gnt1 ? (s.stall | full) : 1'b1;
    assign m1.ack   = gnt1 & s.ack;
    assign m1.dat_i = gnt1 ? s.dat_i : '0;

    // Outstanding counter; a stray ack at zero is ignored
    always_comb begin
        outst_nxt = outst;
        if (issue && !s.ack) begin
            outst_nxt = outst + CW'(1);
        end else if (!issue && s.ack && busy) begin
            outst_nxt = outst - CW'(1);
        end
    end

    // Grant FSM next state; last records the most recently released master
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_nxt = GNT0;
                end else if (m1.cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc && !busy) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1.cyc && !busy) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            outst <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            outst <= outst_nxt;
        end
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning maximum outstanding (issued, un-acked) transfers on the shared bus (1..15).
REQ-002 SHALL have port clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port m0  if_wb.slave  16-bit data  master 0 (higher priority on first contention after reset).
REQ-005 SHALL have port m1  if_wb.slave  16-bit data  master 1.
REQ-006 SHALL have port s  if_wb.master  16-bit data  shared slave bus (e.g. wb_io).
REQ-007 SHALL leave the clk/rst members of the three interfaces unused; clk and rst_n govern all state.

Function
REQ-008 SHALL keep a registered grant FSM with states IDLE, GNT0 and GNT1.
REQ-009 IDLE: a request is reqN = mN.cyc; if only one master requests, the FSM SHALL move to that master's GNT state on the next edge.
REQ-010 IDLE, both request: the FSM SHALL grant the master not served last (round-robin bit last; last=1 after reset, so m0 wins first).
REQ-011 GNTn SHALL hold while mN.cyc=1 or outst!=0 (bus lock for the whole cycle).
REQ-012 GNTn SHALL return to IDLE on the edge where mN.cyc=0 and outst=0, and SHALL set last=n.
REQ-013 Arbitration latency SHALL be 1 cycle: cyc rising at edge k gives first forwarded stb at cycle k+1; no IDLE-to-GNT bypass.
REQ-014 When GNTn: s.cyc, s.stb, s.we, s.adr and s data-out SHALL equal master n's signals combinationally.
REQ-015 When IDLE: s.cyc=0 and s.stb=0, and s.we, s.adr and s data-out SHALL be 0.
REQ-016 The granted master's stall SHALL equal s.stall | (outst==MAX_OUTST).
REQ-017 The non-granted master's stall SHALL be 1 whenever its stb=1, and its ack SHALL be 0.
REQ-018 s.stb SHALL be gated to 0 while outst==MAX_OUTST.
REQ-019 The granted master's ack and data-in SHALL equal s.ack and s data-in combinationally.
REQ-020 The non-granted master's data-in SHALL be 0.
REQ-021 outst SHALL be a counter of width $clog2(MAX_OUTST+1), updated each cycle as +1 on issue, -1 on s.ack, unchanged on both or neither (issue = s.stb & ~s.stall).
REQ-022 outst SHALL saturate at 0 on a spurious ack (no underflow) and SHALL never exceed MAX_OUTST.
REQ-023 If the granted master drops cyc with outst>0, the FSM SHALL stay in GNTn with s.cyc held at 1 and s.stb=0 until outst=0; the remaining acks SHALL be routed to master n.
REQ-024 A request from the other master during GNTn SHALL only see stall=1, and SHALL be granted 1 cycle after the release edge.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, outst=0 and last=1.
REQ-026 During and immediately after reset, s.cyc=0, s.stb=0, both acks=0, and the stalls SHALL follow REQ-017.
REQ-027 Reset in mid-transfer SHALL abandon outstanding transfers; late acks after reset SHALL be ignored (saturation, REQ-022).

Structure
REQ-028 Shared package wb_pkg SHALL hold the typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t and the bus width constant WB_DW=16.
REQ-029 SHALL be a single module with no sub-modules; the outstanding counter stays inline.
REQ-030 Target size SHALL be 120-250 lines of RTL.

Verification
REQ-031 Single master: m0 issues 3 pipelined reads to wb_io (waitcycles=0) -> first s.stb 1 cycle after cyc, 3 acks routed to m0, m1.ack=0 throughout.
REQ-032 Simultaneous cyc from m0 and m1 after reset -> m0 granted first, m1 sees stall=1 until m0 releases, m1 granted 1 cycle later, next tie goes to m0 again.
REQ-033 Outstanding limit, MAX_OUTST=2, slave acks delayed 4 cycles -> outst peaks at 2, m0.stall=1 while full, no third s.stb until an ack arrives.
REQ-034 m0 drops cyc with 2 transfers outstanding -> s.cyc stays 1, both acks reach m0, then IDLE; pending m1 request granted on the following edge.
REQ-035 rst_n pulsed low mid-transfer -> immediate s.cyc=0 and outst=0; a stray s.ack afterwards leaves outst=0 and produces no master ack.
